pll_lock_sequencer: RTL

Controller that sequences the software PLL through open-loop preset, closed-loop acquisition, lock and holdover. It drives the PLL's `freq_rdy` (fixed-f0 mode) and `swiptAlive` (loop enable) inputs. It qualifies lock from per-comparison phase-error magnitudes and watches the incoming `link` reference for loss. It sits between the system enable/status logic and the PLL instance.

---
 rtl/pll_ctrl_pkg.sv | 26 ++
 rtl/pll_lock_sequencer_link_watchdog.sv | 52 +++++
 rtl/pll_lock_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
//   Shared definitions for the PLL lock sequencer: state encodings, the
//   state-register width and the default values of every tunable parameter.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRESET   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ACQUIRE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOCKED   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLDOVER = 3'd4;
  localparam logic [STATE_W-1:0] ST_FAULT    = 3'd5;

  localparam int DEF_ERR_W         = 16;
  localparam int DEF_CNT_W         = 24;
  localparam int DEF_PRESET_CYCLES = 4096;
  localparam int DEF_LOCK_THRESH   = 64;
  localparam int DEF_UNLOCK_THRESH = 256;
  localparam int DEF_LOCK_COUNT    = 8;
  localparam int DEF_UNLOCK_COUNT  = 4;
  localparam int DEF_ACQ_TIMEOUT   = 1000000;
  localparam int DEF_LINK_TIMEOUT  = 10000;
  localparam int DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/pll_lock_sequencer_link_watchdog.sv
// link_watchdog
//   Detects rising edges on the (already synchronised) link reference and
//   declares the link lost when no edge has been seen for LINK_TIMEOUT cycles.
// Ports:
//   i_clk   clock
//   i_nrst  synchronous active-high reset
//   i_link  reference pulse train
//   o_edge  registered rising-edge strobe (one cycle after the edge)
//   o_lost  counter has run out since the last detected edge
module link_watchdog
  import pll_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LINK_TIMEOUT = DEF_LINK_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_link,
  output logic o_edge,
  output logic o_lost
);

  logic             r_link_q;
  logic             r_edge;
  logic [CNT_W-1:0] r_cnt;

  // Edge detector and down-counting timeout that reloads on each edge.
  always_ff @(posedge i_clk) begin
    if (i_nrst) begin
      r_link_q <= 1'b0;
      r_edge   <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_link_q <= i_link;
      r_edge   <= i_link & ~r_link_q;
      // Reload to TIMEOUT-1 so expiry lands exactly LINK_TIMEOUT cycles
      // after the edge strobe.
      if (r_edge) begin
        r_cnt <= CNT_W'(LINK_TIMEOUT - 1);
      end else if (r_cnt != {CNT_W{1'b0}}) begin
        r_cnt <= r_cnt - CNT_W'(1'b1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign o_edge = r_edge;
  // An edge in the same cycle means the link is alive regardless of count.
  assign o_lost = (r_cnt == {CNT_W{1'b0}}) && !r_edge;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Sequences the software PLL through open-loop preset, closed-loop
//   acquisition, lock and holdover, with bounded acquisition retries.
// Ports:
//   clk, nrst (sync, active-high)    clock and reset
//   enable                           request to run the PLL
//   link                             reference pulse train (synchronised)
//   err_valid, err_mag               per-comparison phase-error magnitude
//   freq_rdy, loop_en                PLL control (f0 hold, loop enable)
//   locked, fault                    status; fault is sticky until enable=0
//   retry_cnt, state                 attempts used / current state (debug)
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int ERR_W         = DEF_ERR_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int PRESET_CYCLES = DEF_PRESET_CYCLES,
  parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
  parameter int ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT,
  parameter int LINK_TIMEOUT  = DEF_LINK_TIMEOUT,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               enable,
  input  logic               link,
  input  logic               err_valid,
  input  logic [ERR_W-1:0]   err_mag,
  output logic               freq_rdy,
  output logic               loop_en,
  output logic               locked,
  output logic               fault,
  output logic [1:0]         retry_cnt,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_good_cnt;
  logic [CNT_W-1:0]   r_bad_cnt;
  logic [1:0]         r_retry;
  logic               r_freq_rdy;
  logic               r_loop_en;
  logic               r_locked;
  logic               r_fault;

  logic               w_edge;
  logic               w_lost;
  logic [CNT_W-1:0]   w_good_nxt;
  logic [CNT_W-1:0]   w_bad_nxt;
  logic               w_lock_hit;
  logic               w_unlock_hit;
  logic               w_timer_zero;
  logic               w_link_watched;

  link_watchdog #(
    .CNT_W        (CNT_W),
    .LINK_TIMEOUT (LINK_TIMEOUT)
  ) u_link_watchdog (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_link (link),
    .o_edge (w_edge),
    .o_lost (w_lost)
  );

  // Saturating good/bad sample counters as they would be after this cycle.
  always_comb begin
    w_good_nxt = r_good_cnt;
    w_bad_nxt  = r_bad_cnt;
    if (err_valid) begin
      if (err_mag < ERR_W'(LOCK_THRESH)) begin
        w_good_nxt = (&r_good_cnt) ? r_good_cnt : r_good_cnt + CNT_W'(1'b1);
      end else begin
        w_good_nxt = {CNT_W{1'b0}};
      end
      if (err_mag >= ERR_W'(UNLOCK_THRESH)) begin
        w_bad_nxt = (&r_bad_cnt) ? r_bad_cnt : r_bad_cnt + CNT_W'(1'b1);
      end else begin
        w_bad_nxt = {CNT_W{1'b0}};
      end
    end else begin
      w_good_nxt = r_good_cnt;
      w_bad_nxt  = r_bad_cnt;
    end
  end

  // Qualification uses the post-update count so lock shows one cycle
  // after the qualifying strobe.
  assign w_lock_hit     = (w_good_nxt >= CNT_W'(LOCK_COUNT));
  assign w_unlock_hit   = (w_bad_nxt >= CNT_W'(UNLOCK_COUNT));
  assign w_timer_zero   = (r_timer == {CNT_W{1'b0}});
  assign w_link_watched = (r_state == ST_PRESET) || (r_state == ST_ACQUIRE) ||
                          (r_state == ST_LOCKED);

  // Next-state logic: enable drop, then link loss, then per-state rules.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else if (w_lost && w_link_watched) begin
      w_state_nxt = ST_HOLDOVER;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = w_edge ? ST_PRESET : ST_IDLE;
        ST_PRESET:   w_state_nxt = w_timer_zero ? ST_ACQUIRE : ST_PRESET;
        ST_ACQUIRE: begin
          // Lock takes precedence over a coincident timeout.
          if (w_lock_hit) begin
            w_state_nxt = ST_LOCKED;
          end else if (w_timer_zero) begin
            w_state_nxt = (r_retry < 2'(MAX_RETRY)) ? ST_PRESET : ST_FAULT;
          end else begin
            w_state_nxt = ST_ACQUIRE;
          end
        end
        ST_LOCKED:   w_state_nxt = w_unlock_hit ? ST_ACQUIRE : ST_LOCKED;
        ST_HOLDOVER: w_state_nxt = w_edge ? ST_ACQUIRE : ST_HOLDOVER;
        ST_FAULT:    w_state_nxt = ST_FAULT;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, phase timer, sample counters, retry count and output registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= ST_IDLE;
      r_timer    <= {CNT_W{1'b0}};
      r_good_cnt <= {CNT_W{1'b0}};
      r_bad_cnt  <= {CNT_W{1'b0}};
      r_retry    <= 2'd0;
      r_freq_rdy <= 1'b0;
      r_loop_en  <= 1'b0;
      r_locked   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Timer is shared: loaded on entry to PRESET or ACQUIRE, else counts down.
      if ((w_state_nxt == ST_PRESET) && (r_state != ST_PRESET)) begin
        r_timer <= CNT_W'(PRESET_CYCLES - 1);
      end else if ((w_state_nxt == ST_ACQUIRE) && (r_state != ST_ACQUIRE)) begin
        r_timer <= CNT_W'(ACQ_TIMEOUT - 1);
      end else if (!w_timer_zero) begin
        r_timer <= r_timer - CNT_W'(1'b1);
      end else begin
        r_timer <= r_timer;
      end

      // Counters only run while staying in their own state; any entry clears.
      r_good_cnt <= ((r_state == ST_ACQUIRE) && (w_state_nxt == ST_ACQUIRE)) ?
                    w_good_nxt : {CNT_W{1'b0}};
      r_bad_cnt  <= ((r_state == ST_LOCKED) && (w_state_nxt == ST_LOCKED)) ?
                    w_bad_nxt : {CNT_W{1'b0}};

      if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOCKED)) begin
        r_retry <= 2'd0;
      end else if ((r_state == ST_ACQUIRE) && (w_state_nxt == ST_PRESET)) begin
        r_retry <= r_retry + 2'd1;
      end else begin
        r_retry <= r_retry;
      end

      r_freq_rdy <= (w_state_nxt == ST_PRESET);
      r_loop_en  <= (w_state_nxt == ST_PRESET) || (w_state_nxt == ST_ACQUIRE) ||
                    (w_state_nxt == ST_LOCKED);
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_fault    <= (w_state_nxt == ST_FAULT);
    end
  end

  assign freq_rdy  = r_freq_rdy;
  assign loop_en   = r_loop_en;
  assign locked    = r_locked;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule
